uart_rx: RTL
============

Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 by default, with oversampled mid-bit sampling.
- Sits directly upstream of the byte-to-sample assembler. Drives its 8-bit frame input and its one-cycle ready strobe from the board RX pin.
- Delivers each received byte with a single-cycle valid pulse. Flags bad stop bits and drops those bytes.

Parameters:
- CLK_FREQ, 100000000: in_clk frequency in Hz.
- BAUD, 115200: line bit rate in bits/s.
- OVERSAMPLE, 16: ticks per bit period; must be even and ≥ 4.
- Derived, not overridable: DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer truncation, must be ≥ 1.

Ports:
- in_clk, input, 1: system clock.
- in_rst, input, 1: synchronous, active-high reset.
- in_uart_rx, input, 1: asynchronous serial line; idle high.
- out_uart_frame, output, 8: last correctly received byte, LSB first on the wire.
- out_uart_ready, output, 1: one-cycle strobe; out_uart_frame is valid in that cycle.
- out_frame_err, output, 1: one-cycle strobe on stop-bit error.
- out_busy, output, 1: high while not in IDLE.

Behaviour:
- Clock and reset: one clock domain; in_rst is sampled only on rising in_clk (synchronous, active-high).
- Reset values:
  - out_uart_frame = 8'h00; out_uart_ready, out_frame_err, out_busy = 0.
  - State = IDLE; synchronizer flops = 1; all counters = 0.
- Reset asserted mid-frame aborts the frame immediately, with no strobe.
- Input sync: 2-flop synchronizer on in_uart_rx. All decisions use the second flop (rx_s).
- Tick generator: counter 0..DIV-1, tick when it equals DIV-1. Held at 0 in IDLE, so ticks align to start-edge detection.
- Tick counter: 0..OVERSAMPLE-1, advanced per tick. Bit counter: 0..7.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s == 0 → START, with counters cleared.
  - START: after OVERSAMPLE/2 ticks (mid start bit), re-check rx_s.
    - rx_s == 0 → DATA, tick count cleared.
    - rx_s == 1 → IDLE (glitch or false start); no strobe.
  - DATA: every OVERSAMPLE ticks, shift rx_s into the shift register MSB, shifting right (LSB first on the wire). After the 8th bit → STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s == 1: out_uart_frame <= shift register, out_uart_ready = 1 for exactly one in_clk cycle, → IDLE.
    - rx_s == 0: out_frame_err = 1 for one cycle, out_uart_frame unchanged, no ready, → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1 (break condition), then → IDLE.
- Strobe timing: strobes assert in the cycle after the mid-stop sample.
- Single-cycle strobe is mandatory: the downstream assembler counts every high cycle as a byte.
- out_uart_frame holds its value until the next valid byte.
- Back-to-back frames: a start bit right after the mid-stop sample is accepted. IDLE is entered in time for a zero-length stop gap at half a bit of margin.
- out_busy = (state != IDLE).
- Line held low from reset: START → DATA → STOP error → WAIT_IDLE. Exactly one out_frame_err pulse, none repeated.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and output out_parity_err (1 bit, resets 0).
  - Adds a PARITY state between DATA and STOP; it samples the 9th bit at mid-bit.
  - On a good stop bit with a parity mismatch: out_parity_err pulses one cycle, out_uart_ready does not pulse, out_uart_frame is not updated.
  - Stop-bit error takes precedence; only out_frame_err pulses.
- Undefined: no PARITY state, no out_parity_err port, plain 8N1.

Test Plan:
- Bench setup: CLK_FREQ=16000000, BAUD=1000000, OVERSAMPLE=16, so DIV=1 and 16 clocks per bit.
- Send 8'hA5 8N1 → exactly one out_uart_ready pulse; out_uart_frame=8'hA5; it holds after the pulse; out_busy low after the pulse.
- Send 8'h34 then 8'h12 back-to-back, zero idle gap → two single-cycle ready pulses, frames 8'h34 then 8'h12. Downstream assembler outputs 16'h1234.
- Low glitch of 4 clocks on an idle line → returns to IDLE; no ready, no frame_err; out_uart_frame unchanged.
- Send 8'h5A with the stop bit forced 0, line held low 40 more clocks, then high → one out_frame_err pulse, no ready, frame keeps its old value. Next byte 8'hC3 is received correctly.
- Assert in_rst for 1 cycle during data bit 3 of 8'hFF → all outputs 0, no strobe. Next full byte 8'h0F is received correctly.
- With UART_RX_PARITY_EN, PARITY_ODD=0: send 8'h07 with parity bit 1 → ready, frame 8'h07. Send 8'h07 with parity bit 0 → out_parity_err pulse, no ready.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver, 8N1 by default.
// A 2-flop synchronizer feeds a tick-driven FSM that samples every bit at
// its midpoint. Good bytes leave with a one-cycle out_uart_ready strobe.
// Bad stop bits raise a one-cycle out_frame_err strobe and the byte is dropped.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit before the stop
// bit, the PARITY_ODD parameter and the out_parity_err strobe.
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_uart_rx,
    output logic [7:0] out_uart_frame,
    output logic       out_uart_ready,
    output logic       out_frame_err,
    output logic       out_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       out_parity_err
`endif
);

    // Clocks per oversampling tick; intentionally truncated.
    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e              state_q, state_d;
    logic                rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          frame_q, frame_d;
    logic                ready_q, ready_d;
    logic                frame_err_q, frame_err_d;
    logic                tick;
    logic                bit_done;
`ifdef UART_RX_PARITY_EN
    logic                par_bit_q, par_bit_d;
    logic                parity_err_q, parity_err_d;
    logic                parity_ok;
`endif

    // The tick generator only runs outside IDLE, so tick phase follows the start edge.
    assign tick     = (state_q != S_IDLE) && (div_q == DIV_LAST);
    // One full bit period has elapsed on this tick.
    assign bit_done = tick && (tick_cnt_q == TICK_LAST);
`ifdef UART_RX_PARITY_EN
    // Data bits plus parity bit must XOR to the selected parity sense.
    assign parity_ok = ((^shift_q) ^ par_bit_q) == PARITY_ODD;
`endif

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge in_clk) begin
        // NOTE: flops use non-blocking assignment so every register samples
        // pre-edge values; blocking here would collapse the two sync stages.
        if (in_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= in_uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, shift register and output strobes.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_q     <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_q     <= frame_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic: mid-bit sampling, byte assembly and strobe generation.
    always_comb begin
        // NOTE: every output of this block gets a default first; any path that
        // left one unassigned would infer a latch.
        state_d     = state_q;
        div_d       = div_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_d     = frame_q;
        ready_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                div_d      = '0;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // Re-check the line at the middle of the start bit.
                if (tick && (tick_cnt_q == TICK_HALF)) begin
                    tick_cnt_d = '0;
                    state_d    = rx_s_q ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    tick_cnt_d = '0;
                    par_bit_d  = rx_s_q;
                    state_d    = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (bit_done) begin
                    tick_cnt_d = '0;
                    if (rx_s_q) begin
                        // Return to IDLE at mid-stop so a following start bit is caught.
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_ok) begin
                            frame_d = shift_q;
                            ready_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
`else
                        frame_d = shift_q;
                        ready_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // Wait out a break so a held-low line yields only one error.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_uart_frame = frame_q;
    assign out_uart_ready = ready_q;
    assign out_frame_err  = frame_err_q;
    assign out_busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign out_parity_err = parity_err_q;
`endif

endmodule
